// File: rtl/dmem_access_ctrl.sv
// dmem_access_ctrl: initiator-side sequencer for a synchronous single-port RAM.
// Turns valid/ready load/store requests into registered RAM control, waits
// out the RAM read latency, returns load data on a valid/ready response
// channel, and can zero-fill the whole memory on request.
module dmem_access_ctrl #(
    parameter int ADDR_W     = 4,
    parameter int DATA_W     = 4,
    parameter int RD_LATENCY = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              wr_done,
    input  logic              clear_start,
    output logic              clear_done,
    output logic              busy,
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_data,
    output logic              mem_wren,
    input  logic [DATA_W-1:0] mem_q
);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        STORE     = 3'd1,
        LOAD_WAIT = 3'd2,
        LOAD_RSP  = 3'd3,
        CLEAR     = 3'd4
    } state_t;

    // Clear pointer value that means the last address has already been issued.
    localparam logic [ADDR_W:0] CLR_END  = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [1:0]      RD_LAT_C = 2'(RD_LATENCY);

    state_t            state;
    state_t            state_nxt;
    logic [1:0]        lat_cnt;
    logic [ADDR_W:0]   clr_ptr;

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode; clear_start wins over a same-cycle request
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (clear_start) begin
                    state_nxt = CLEAR;
                end else if (req_valid) begin
                    state_nxt = req_we ? STORE : LOAD_WAIT;
                end
            end
            STORE:     state_nxt = IDLE;
            LOAD_WAIT: if (lat_cnt == 2'd0) state_nxt = LOAD_RSP;
            LOAD_RSP:  if (rsp_ready) state_nxt = IDLE;
            CLEAR:     if (clr_ptr == CLR_END) state_nxt = IDLE;
            default:   state_nxt = IDLE;
        endcase
    end

    // Handshake outputs decoded directly from the state
    always_comb begin
        req_ready = (state == IDLE);
        busy      = (state != IDLE);
    end

    // Registered RAM control, response data, latency counter and clear pointer.
    // clr_ptr holds the next address to clear: address 0 is issued on entry,
    // so the pointer starts at 1 and reaching 2**ADDR_W means all are written.
    always_ff @(posedge clk) begin
        if (reset) begin
            mem_address <= '0;
            mem_data    <= '0;
            mem_wren    <= 1'b0;
            rsp_valid   <= 1'b0;
            rsp_rdata   <= '0;
            wr_done     <= 1'b0;
            clear_done  <= 1'b0;
            lat_cnt     <= 2'd0;
            clr_ptr     <= '0;
        end else begin
            mem_wren   <= 1'b0;
            wr_done    <= 1'b0;
            clear_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (clear_start) begin
                        mem_address <= '0;
                        mem_data    <= '0;
                        mem_wren    <= 1'b1;
                        clr_ptr     <= {{ADDR_W{1'b0}}, 1'b1};
                    end else if (req_valid) begin
                        mem_address <= req_addr;
                        if (req_we) begin
                            mem_data <= req_wdata;
                            mem_wren <= 1'b1;
                        end else begin
                            lat_cnt <= RD_LAT_C;
                        end
                    end
                end
                STORE: begin
                    wr_done <= 1'b1;
                end
                LOAD_WAIT: begin
                    if (lat_cnt == 2'd0) begin
                        rsp_rdata <= mem_q;
                        rsp_valid <= 1'b1;
                    end else begin
                        lat_cnt <= lat_cnt - 2'd1;
                    end
                end
                LOAD_RSP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                    end
                end
                CLEAR: begin
                    if (clr_ptr == CLR_END) begin
                        clear_done <= 1'b1;
                    end else begin
                        mem_address <= clr_ptr[ADDR_W-1:0];
                        mem_data    <= '0;
                        mem_wren    <= 1'b1;
                        clr_ptr     <= clr_ptr + 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// tb_dmem_access_ctrl: drives dmem_access_ctrl against a behavioural
// synchronous RAM and compares load results with a word-array memory model.
module tb_dmem_access_ctrl;

    localparam int ADDR_W = 4;
    localparam int DATA_W = 4;
    localparam int RDL    = 1;
    localparam int DEPTH  = 16;

    logic              clk = 1'b0;
    logic              reset;
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_rdata;
    logic              wr_done;
    logic              clear_start;
    logic              clear_done;
    logic              busy;
    logic [ADDR_W-1:0] mem_address;
    logic [DATA_W-1:0] mem_data;
    logic              mem_wren;
    logic [DATA_W-1:0] mem_q;

    dmem_access_ctrl #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LATENCY(RDL)
    ) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .wr_done(wr_done), .clear_start(clear_start), .clear_done(clear_done),
        .busy(busy), .mem_address(mem_address), .mem_data(mem_data),
        .mem_wren(mem_wren), .mem_q(mem_q)
    );

    always #5 clk = ~clk;

    // Behavioural data_memory: registered read with RDL cycles of latency.
    logic [DATA_W-1:0] ram    [DEPTH] = '{default: 4'h9};
    logic [DATA_W-1:0] q_pipe [RDL]   = '{default: 4'h0};
    always @(posedge clk) begin
        if (mem_wren) ram[mem_address] <= mem_data;
        q_pipe[0] <= ram[mem_address];
        for (int i = 1; i < RDL; i++) q_pipe[i] <= q_pipe[i-1];
    end
    assign mem_q = q_pipe[RDL-1];

    // Event counters sampled at each active edge.
    int wren_cnt = 0, wrdone_cnt = 0, clrdone_cnt = 0;
    always @(posedge clk) begin
        if (mem_wren)   wren_cnt    <= wren_cnt + 1;
        if (wr_done)    wrdone_cnt  <= wrdone_cnt + 1;
        if (clear_done) clrdone_cnt <= clrdone_cnt + 1;
    end

    logic [DATA_W-1:0] ref_mem [DEPTH];
    int n_checks = 0;
    int n_fail   = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_store(input logic [3:0] a, input logic [3:0] d, output int lat);
        req_valid = 1'b1; req_we = 1'b1; req_addr = a; req_wdata = d;
        tick();
        req_valid = 1'b0; req_we = 1'b0;
        ref_mem[a] = d;
        lat = -1;
        for (int i = 1; i <= 8; i++) begin
            tick();
            if (wr_done) begin lat = i; break; end
        end
    endtask

    task automatic do_load(input logic [3:0] a, output logic [3:0] data, output int lat);
        req_valid = 1'b1; req_we = 1'b0; req_addr = a;
        tick();
        req_valid = 1'b0;
        lat = -1;
        data = 4'hx;
        for (int i = 1; i <= 12; i++) begin
            tick();
            if (rsp_valid) begin lat = i; break; end
        end
        data = rsp_rdata;
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
    endtask

    task automatic do_clear(output int cyc);
        clear_start = 1'b1;
        tick();
        clear_start = 1'b0;
        cyc = -1;
        for (int i = 1; i <= 40; i++) begin
            tick();
            if (clear_done) begin cyc = i; break; end
        end
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = 4'h0;
    endtask

    task automatic test_reset();
        int cyc, lat;
        logic [3:0] d;
        reset = 1'b1;
        repeat (3) tick();
        n_checks++;
        if (req_ready !== 1'b1) begin
            n_fail++; $display("FAIL reset_req_ready: got %b want 1", req_ready);
        end
        n_checks++;
        if ({rsp_valid, wr_done, clear_done, busy, mem_wren} !== 5'b0) begin
            n_fail++; $display("FAIL reset_ctrl_outs: got %b want 00000",
                                {rsp_valid, wr_done, clear_done, busy, mem_wren});
        end
        n_checks++;
        if ({mem_address, mem_data, rsp_rdata} !== 12'h000) begin
            n_fail++; $display("FAIL reset_data_outs: got %h want 000",
                                {mem_address, mem_data, rsp_rdata});
        end
        reset = 1'b0;
        tick();
        n_checks++;
        if (req_ready !== 1'b1 || busy !== 1'b0) begin
            n_fail++; $display("FAIL post_reset_idle: ready=%b busy=%b want 1/0", req_ready, busy);
        end
        do_clear(cyc);
        n_checks++;
        if (cyc !== DEPTH) begin
            n_fail++; $display("FAIL reset_clear_len: got %0d want %0d", cyc, DEPTH);
        end
        do_load(4'h0, d, lat);
        n_checks++;
        if (d !== ref_mem[0] || lat !== RDL + 1) begin
            n_fail++; $display("FAIL load_after_clear: data=%h lat=%0d want %h lat=%0d",
                                d, lat, ref_mem[0], RDL + 1);
        end
    endtask

    task automatic test_store_load();
        logic [3:0] sa [3] = '{4'h0, 4'h1, 4'h5};
        logic [3:0] sd [3] = '{4'hA, 4'hB, 4'hF};
        logic [3:0] d;
        int lat, w0, d0;
        for (int i = 0; i < 3; i++) begin
            w0 = wren_cnt; d0 = wrdone_cnt;
            do_store(sa[i], sd[i], lat);
            tick();
            n_checks++;
            if (lat !== 1 || wren_cnt - w0 !== 1 || wrdone_cnt - d0 !== 1) begin
                n_fail++; $display("FAIL store_%0d: lat=%0d wren=%0d done=%0d want 1/1/1",
                                    i, lat, wren_cnt - w0, wrdone_cnt - d0);
            end
        end
        for (int i = 0; i < 3; i++) begin
            do_load(sa[i], d, lat);
            n_checks++;
            if (d !== ref_mem[sa[i]] || lat !== RDL + 1) begin
                n_fail++; $display("FAIL load_%0d: data=%h lat=%0d want %h lat=%0d",
                                    i, d, lat, ref_mem[sa[i]], RDL + 1);
            end
        end
    endtask

    task automatic test_backpressure();
        int w0, lat, stalls;
        logic [3:0] d;
        req_valid = 1'b1; req_we = 1'b0; req_addr = 4'h5;
        tick();
        req_valid = 1'b0;
        lat = -1;
        for (int i = 1; i <= 12; i++) begin
            tick();
            if (rsp_valid) begin lat = i; break; end
        end
        n_checks++;
        if (lat !== RDL + 1) begin
            n_fail++; $display("FAIL bp_latency: got %0d want %0d", lat, RDL + 1);
        end
        w0 = wren_cnt;
        req_valid = 1'b1; req_we = 1'b1; req_addr = 4'h3; req_wdata = 4'h7;
        stalls = 0;
        for (int k = 0; k < 4; k++) begin
            if (rsp_valid !== 1'b1 || rsp_rdata !== ref_mem[5] || req_ready !== 1'b0) stalls++;
            tick();
        end
        n_checks++;
        if (stalls !== 0 || rsp_valid !== 1'b1 || rsp_rdata !== ref_mem[5]) begin
            n_fail++; $display("FAIL bp_hold: bad_cycles=%0d valid=%b data=%h want 0/1/%h",
                                stalls, rsp_valid, rsp_rdata, ref_mem[5]);
        end
        req_valid = 1'b0; req_we = 1'b0;
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        n_checks++;
        if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
            n_fail++; $display("FAIL bp_release: valid=%b ready=%b want 0/1", rsp_valid, req_ready);
        end
        tick();
        n_checks++;
        if (wren_cnt !== w0) begin
            n_fail++; $display("FAIL bp_no_accept: wren cycles=%0d want 0", wren_cnt - w0);
        end
        do_load(4'h3, d, lat);
        n_checks++;
        if (d !== ref_mem[3]) begin
            n_fail++; $display("FAIL bp_addr3: got %h want %h", d, ref_mem[3]);
        end
    endtask

    task automatic test_clear_priority();
        int lat, w0, d0, c0, n, seq_err;
        logic [3:0] d;
        do_store(4'h2, 4'hC, lat);
        tick();
        w0 = wren_cnt; d0 = wrdone_cnt; c0 = clrdone_cnt;
        clear_start = 1'b1;
        req_valid = 1'b1; req_we = 1'b1; req_addr = 4'h2; req_wdata = 4'h3;
        tick();
        clear_start = 1'b0; req_valid = 1'b0; req_we = 1'b0;
        n_checks++;
        if (req_ready !== 1'b0 || busy !== 1'b1) begin
            n_fail++; $display("FAIL clr_enter: ready=%b busy=%b want 0/1", req_ready, busy);
        end
        n = 0; seq_err = 0;
        for (int i = 0; i < 40; i++) begin
            if (clear_done) break;
            if (mem_wren) begin
                if (mem_address !== n[3:0] || mem_data !== 4'h0) seq_err++;
                n++;
            end
            tick();
        end
        n_checks++;
        if (n !== DEPTH || seq_err !== 0 || clear_done !== 1'b1) begin
            n_fail++; $display("FAIL clr_seq: writes=%0d errs=%0d done=%b want %0d/0/1",
                                n, seq_err, clear_done, DEPTH);
        end
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = 4'h0;
        tick();
        n_checks++;
        if (clear_done !== 1'b0 || wren_cnt - w0 !== DEPTH || wrdone_cnt !== d0 || clrdone_cnt - c0 !== 1) begin
            n_fail++; $display("FAIL clr_counts: done=%b wren=%0d stores=%0d pulses=%0d want 0/%0d/0/1",
                                clear_done, wren_cnt - w0, wrdone_cnt - d0, clrdone_cnt - c0, DEPTH);
        end
        do_load(4'h2, d, lat);
        n_checks++;
        if (d !== ref_mem[2]) begin
            n_fail++; $display("FAIL clr_addr2: got %h want %h", d, ref_mem[2]);
        end
    endtask

    task automatic test_reset_mid_clear();
        int lat, w0, c0;
        logic [3:0] d;
        do_store(4'hA, 4'hE, lat);
        clear_start = 1'b1;
        tick();
        clear_start = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (mem_wren && mem_address == 4'h6) break;
            tick();
        end
        reset = 1'b1;
        tick();
        n_checks++;
        if (mem_wren !== 1'b0 || busy !== 1'b0 || req_ready !== 1'b1 || clear_done !== 1'b0) begin
            n_fail++; $display("FAIL mid_clear_reset: wren=%b busy=%b ready=%b done=%b want 0/0/1/0",
                                mem_wren, busy, req_ready, clear_done);
        end
        reset = 1'b0;
        for (int i = 0; i <= 6; i++) ref_mem[i] = 4'h0;
        w0 = wren_cnt; c0 = clrdone_cnt;
        repeat (20) tick();
        n_checks++;
        if (wren_cnt !== w0 || clrdone_cnt !== c0) begin
            n_fail++; $display("FAIL clear_not_resumed: wren=%0d pulses=%0d want 0/0",
                                wren_cnt - w0, clrdone_cnt - c0);
        end
        do_load(4'hA, d, lat);
        n_checks++;
        if (d !== ref_mem[10]) begin
            n_fail++; $display("FAIL mid_clear_addrA: got %h want %h", d, ref_mem[10]);
        end
    endtask

    task automatic test_no_valid_store();
        int w0, lat;
        logic [3:0] d;
        w0 = wren_cnt;
        req_valid = 1'b0; req_we = 1'b1; req_addr = 4'h0; req_wdata = 4'hA;
        repeat (3) tick();
        req_we = 1'b0;
        tick();
        n_checks++;
        if (wren_cnt !== w0) begin
            n_fail++; $display("FAIL no_valid_wren: got %0d cycles want 0", wren_cnt - w0);
        end
        do_load(4'h0, d, lat);
        n_checks++;
        if (d !== ref_mem[0]) begin
            n_fail++; $display("FAIL no_valid_load: got %h want %h", d, ref_mem[0]);
        end
    endtask

    task automatic test_back_to_back();
        int l1, l2;
        logic [3:0] d;
        do_store(4'h8, 4'h1, l1);
        do_store(4'h9, 4'h2, l2);
        n_checks++;
        if (l1 !== 1 || l2 !== 1) begin
            n_fail++; $display("FAIL b2b_stores: lat=%0d/%0d want 1/1", l1, l2);
        end
        do_store(4'h7, 4'h5, l1);
        do_load(4'h7, d, l2);
        n_checks++;
        if (d !== ref_mem[7] || l2 !== RDL + 1) begin
            n_fail++; $display("FAIL b2b_raw: data=%h lat=%0d want %h lat=%0d", d, l2, ref_mem[7], RDL + 1);
        end
        do_load(4'h8, d, l2);
        n_checks++;
        if (d !== ref_mem[8]) begin
            n_fail++; $display("FAIL b2b_addr8: got %h want %h", d, ref_mem[8]);
        end
    endtask

    task automatic test_random();
        logic [3:0] a, wd, d;
        int lat;
        for (int i = 0; i < 40; i++) begin
            a  = 4'($urandom_range(0, DEPTH - 1));
            wd = 4'($urandom);
            if ($urandom_range(0, 1) == 1) begin
                do_store(a, wd, lat);
                n_checks++;
                if (lat !== 1) begin
                    n_fail++; $display("FAIL rand_store_%0d: lat=%0d want 1", i, lat);
                end
            end else begin
                do_load(a, d, lat);
                n_checks++;
                if (d !== ref_mem[a] || lat !== RDL + 1) begin
                    n_fail++; $display("FAIL rand_load_%0d: addr=%h data=%h lat=%0d want %h lat=%0d",
                                        i, a, d, lat, ref_mem[a], RDL + 1);
                end
            end
        end
    endtask

    initial begin
        reset = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0;
        rsp_ready = 1'b0; clear_start = 1'b0;
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = 4'h9;
        test_reset();
        test_store_load();
        test_backpressure();
        test_clear_priority();
        test_reset_mid_clear();
        test_no_valid_store();
        test_back_to_back();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d", n_checks);
        $fatal(1, "time limit");
    end

endmodule
